// File: rtl/nibble_serial_add_ctrl.sv
// Multi-precision adder that reuses one 4-bit ripple slice, one nibble per cycle, LSB first.
// Optional subtract mode (SUB port) is compiled in with NIBBLE_SERIAL_ADD_SUB_EN.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 CIN,
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  input  logic                 SUB,
`endif
  output logic                 READY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*NIBBLES-1:0] SUM,
  output logic                 COUT,
  output logic                 OVF
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [W-1:0]    a_sh_r;
  logic [W-1:0]    b_sh_r;
  logic [W-1:0]    sum_r;
  logic [IW-1:0]   idx_r;
  logic            carry_r;
  logic            cout_r;
  logic            ovf_r;
  logic            ready_r;
  logic            busy_r;
  logic            done_r;
  logic [4:0]      add_s;
  logic            accept_s;
  logic            last_s;
  logic            sub_s;

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  assign sub_s = SUB;
`else
  assign sub_s = 1'b0;
`endif

  assign READY = ready_r;
  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign SUM   = sum_r;
  assign COUT  = cout_r;
  assign OVF   = ovf_r;

  // Next-state decode plus the shared 4-bit slice fed from the operand shifters.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    last_s   = (idx_r == IW'(NIBBLES - 1));
    add_s    = {1'b0, a_sh_r[3:0]} + {1'b0, b_sh_r[3:0]} + {4'b0000, carry_r};
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          accept_s = 1'b1;
          state_s  = ST_RUN;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake flags registered from the next state so they line up with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_s != ST_RUN);
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Operand latch, per-nibble result write and carry chaining.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      a_sh_r  <= A;
      b_sh_r  <= sub_s ? ~B : B;
      carry_r <= sub_s ? 1'b1 : CIN;
      sum_r   <= '0;
      idx_r   <= '0;
    end else if (state_r == ST_RUN) begin
      sum_r[{idx_r, 2'b00} +: 4] <= add_s[3:0];
      carry_r <= add_s[4];
      a_sh_r  <= {4'b0000, a_sh_r[W-1:4]};
      b_sh_r  <= {4'b0000, b_sh_r[W-1:4]};
      idx_r   <= idx_r + IW'(1);
      if (last_s) begin
        // Carry into bit 3 is recovered from the slice operands and sum bit.
        cout_r <= add_s[4];
        ovf_r  <= (a_sh_r[3] ^ b_sh_r[3] ^ add_s[3]) ^ add_s[4];
      end else begin
        cout_r <= cout_r;
        ovf_r  <= ovf_r;
      end
    end else begin
      idx_r <= idx_r;
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Randomized and directed self-checking bench for nibble_serial_add_ctrl (NIBBLES=4),
// compared against a whole-word arithmetic model.
module tb_nibble_serial_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         CIN;
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
  logic         SUB;
`endif
  logic         READY;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         COUT;
  logic         OVF;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .A     (A),
    .B     (B),
    .CIN   (CIN),
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    .SUB   (SUB),
`endif
    .READY (READY),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .COUT  (COUT),
    .OVF   (OVF)
  );

  always #5 CLK = ~CLK;

  // Whole-word reference: returns {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic cin, input logic sub);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full[W], full[W-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_sub(input logic s);
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    SUB = s;
`else
    if (s) $error("FAIL drive_sub: subtract requested without SUB port");
`endif
  endtask

  // Starts from a sample point where READY=1; returns at the DONE sample point.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input string tag);
    logic [W+1:0] e;
    e = model(a, b, cin, sub);
    A = a; B = b; CIN = cin; drive_sub(sub); START = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < NIBBLES; k++) begin
      chk({tag, "_busy"}, 32'(BUSY), 32'd1);
      chk({tag, "_nodone"}, 32'(DONE), 32'd0);
      // Scribble inputs during RUN; none of it may reach the result.
      START = (k < NIBBLES - 1) ? 1'($urandom_range(1, 0)) : 1'b0;
      A = W'($urandom); B = W'($urandom); CIN = 1'($urandom_range(1, 0));
      drive_sub(1'b0);
      @(posedge CLK); #1;
    end
    START = 1'b0;
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    chk({tag, "_ready"}, 32'(READY), 32'd1);
    chk({tag, "_sum"}, 32'(SUM), 32'(e[W-1:0]));
    chk({tag, "_cout"}, 32'(COUT), 32'(e[W]));
    chk({tag, "_ovf"}, 32'(OVF), 32'(e[W+1]));
  endtask

  initial begin
    logic [W+1:0] e;
    logic         rs;
    RST = 1'b1; START = 1'b0; A = '0; B = '0; CIN = 1'b0; drive_sub(1'b0);

    // Reset state
    repeat (2) @(posedge CLK); #1;
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_sum", 32'(SUM), 32'd0);
    chk("rst_cout", 32'(COUT), 32'd0);
    chk("rst_ovf", 32'(OVF), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Directed operations
    run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, "d1234");
    @(posedge CLK); #1;
    chk("idle_ready", 32'(READY), 32'd1);
    chk("idle_hold_sum", 32'(SUM), 32'h2233);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "dffff");
    run_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, "d7fff");
    @(posedge CLK); #1;

    // Back-to-back with held START and A changing during RUN
    A = 16'h0001; B = 16'h0001; CIN = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    A = 16'hAAAA;
    for (int k = 0; k < NIBBLES; k++) begin
      chk("b2b_busy", 32'(BUSY), 32'd1);
      @(posedge CLK); #1;
    end
    chk("b2b_done1", 32'(DONE), 32'd1);
    chk("b2b_sum1", 32'(SUM), 32'h0002);
    @(posedge CLK); #1;
    START = 1'b0;
    chk("b2b_noidle", 32'(BUSY), 32'd1);
    repeat (NIBBLES) @(posedge CLK);
    #1;
    e = model(16'hAAAA, 16'h0001, 1'b0, 1'b0);
    chk("b2b_done2", 32'(DONE), 32'd1);
    chk("b2b_sum2", 32'(SUM), 32'(e[W-1:0]));
    chk("b2b_sum2_const", 32'(SUM), 32'hAAAB);

    // Asynchronous reset two cycles into RUN
    A = 16'hFFFF; B = 16'hFFFF; CIN = 1'b1; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("arst_ready", 32'(READY), 32'd1);
    chk("arst_busy", 32'(BUSY), 32'd0);
    chk("arst_sum", 32'(SUM), 32'd0);
    chk("arst_done", 32'(DONE), 32'd0);
    #2;
    RST = 1'b0;
    for (int k = 0; k < NIBBLES + 2; k++) begin
      @(posedge CLK); #1;
      chk("arst_nodone", 32'(DONE), 32'd0);
    end
    run_op(16'h0F0F, 16'hF0F1, 1'b0, 1'b0, "post_rst");

`ifdef NIBBLE_SERIAL_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub57");
    chk("sub57_const", 32'(SUM), 32'hFFFE);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub8000");
    chk("sub8000_ovf_const", 32'(OVF), 32'd1);
`endif

    // Randomized operations, some back-to-back, some with idle gaps
    for (int i = 0; i < 40; i++) begin
`ifdef NIBBLE_SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(1, 0));
`else
      rs = 1'b0;
`endif
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), rs, "rand");
      if ($urandom_range(1, 0) == 1) begin
        repeat ($urandom_range(3, 1)) @(posedge CLK);
        #1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
